// File: rtl/h264_ddr_pkg.sv
// Shared types and constants for the H.264 DDR frame read path.
package h264_ddr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        FLUSH,
        DONE
    } rd_state_t;

    localparam int unsigned BEAT_BYTES    = 8;
    localparam int unsigned HW_PER_BEAT   = 4;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned ADDR_REGION_W = 10;
    localparam int unsigned ADDR_INDEX_W  = 2;
    localparam int unsigned ADDR_SLOT_W   = 20;

    // Integer ceiling division; callers keep num well below 2^32.
    function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
        return (num + den - 32'd1) / den;
    endfunction

endpackage

// File: rtl/h264_rd_fifo.sv
// Synchronous first-word-fall-through FIFO reporting its free-entry count.
module h264_rd_fifo
    import h264_ddr_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign count   = wptr - rptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign free    = (AW+1)'(DEPTH) - count;
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;
    assign dout    = mem[rptr[AW-1:0]];

    // Read and write pointers, one extra wrap bit to tell full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (AW+1)'(1);
            if (do_pop)  rptr <= rptr + (AW+1)'(1);
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

    // The requester only bursts into guaranteed room, so a push into a full FIFO is a design error
    assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/h264_ddr_read.sv
// Fetches one H.264 frame from its DDR slot over the arbiter r0 port and
// streams it out as 16-bit halfwords with a valid/ready handshake.
// Optional build macro: H264_RD_BYTE_SWAP_EN byte-swaps every output halfword.
module h264_ddr_read
    import h264_ddr_pkg::*;
#(
    parameter int unsigned BURST_BEATS     = 16,
    parameter int unsigned FIFO_DEPTH      = 64,
    parameter int unsigned SLOT_BYTES_LOG2 = 20
) (
    input  logic                     sys_clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [ADDR_REGION_W-1:0] frame_ddr_addr_i,
    input  logic [ADDR_INDEX_W-1:0]  frame_index_i,
    input  logic [31:0]              frame_bytes_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     read_req_o,
    output logic [ADDR_W-1:0]        read_start_addr_o,
    output logic [7:0]               read_length_o,
    input  logic                     read_ackn_i,
    input  logic                     rdata_valid_i,
    input  logic [63:0]              rdata_i,
    input  logic                     read_done_i,
    output logic [15:0]              data_o,
    output logic                     data_valid_o,
    input  logic                     data_ready_i,
    output logic                     last_o
);

    localparam int unsigned LEN_W  = 9;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LEFT_W = SLOT_BYTES_LOG2 + 1;
    localparam logic [31:0] SLOT_BYTES = 32'(1) << SLOT_BYTES_LOG2;

    rd_state_t          state;
    rd_state_t          state_nxt;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEFT_W-1:0]  beats_left;
    logic [LEFT_W-1:0]  hw_left;
    logic [LEN_W-1:0]   pending;
    logic               odd_q;
    logic [31:0]        bytes_c;
    logic [LEN_W-1:0]   len;
    logic               room;
    logic               ack;
    logic               capture;

    logic [63:0]        word_q;
    logic [1:0]         sel_q;
    logic               have_q;
    logic               xfer;
    logic               last_hw;
    logic               word_end;
    logic [15:0]        hw;

    logic [63:0]        fifo_dout;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [CNT_W-1:0]   fifo_free;

    assign bytes_c = (frame_bytes_i > SLOT_BYTES) ? SLOT_BYTES : frame_bytes_i;
    assign len     = (beats_left > LEFT_W'(BURST_BEATS)) ? LEN_W'(BURST_BEATS)
                                                         : beats_left[LEN_W-1:0];
    // Beats already granted but not yet landed count against the free space
    assign room    = (32'(fifo_free) >= (32'(pending) + 32'(len)));
    assign capture = (state == IDLE) && start_i;
    assign ack     = (state == REQ) && room && read_ackn_i;

    assign last_hw  = (hw_left == LEFT_W'(1));
    assign xfer     = have_q && data_ready_i;
    assign word_end = last_hw || (sel_q == 2'(HW_PER_BEAT - 1));
    assign fifo_pop = !fifo_empty && (hw_left != '0) &&
                      (!have_q || (xfer && !last_hw && word_end));

    h264_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (sys_clk_i),
        .rst   (reset_i),
        .push  (rdata_valid_i),
        .din   (rdata_i),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .free  (fifo_free)
    );

    // FSM state register
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_nxt;
    end

    // FSM next-state and bus/status outputs
    always_comb begin
        state_nxt     = state;
        busy_o        = 1'b1;
        done_o        = 1'b0;
        read_req_o    = 1'b0;
        read_length_o = '0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) state_nxt = (bytes_c == '0) ? DONE : REQ;
            end
            REQ: begin
                read_length_o = 8'(len - LEN_W'(1));
                if (room) begin
                    read_req_o = 1'b1;
                    if (read_ackn_i) state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (read_done_i) state_nxt = (beats_left == LEFT_W'(len)) ? FLUSH : REQ;
            end
            FLUSH: begin
                if (hw_left == '0) state_nxt = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign read_start_addr_o = addr_q;

    // Burst address, remaining beats and in-flight beat tracking
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            addr_q     <= '0;
            beats_left <= '0;
            pending    <= '0;
            odd_q      <= 1'b0;
        end else begin
            if (capture) begin
                addr_q     <= {frame_ddr_addr_i, frame_index_i, {ADDR_SLOT_W{1'b0}}};
                beats_left <= LEFT_W'(ceil_div(bytes_c, BEAT_BYTES));
                odd_q      <= bytes_c[0];
            end
            if ((state == WAIT) && read_done_i) begin
                addr_q     <= addr_q + (32'(len) * BEAT_BYTES);
                beats_left <= beats_left - LEFT_W'(len);
            end
            if (ack)                                   pending <= len;
            else if (rdata_valid_i && pending != '0)   pending <= pending - LEN_W'(1);
        end
    end

    // Remaining halfword count for the whole frame
    always_ff @(posedge sys_clk_i) begin
        if (reset_i)      hw_left <= '0;
        else if (capture) hw_left <= LEFT_W'(ceil_div(bytes_c, BEAT_BYTES / HW_PER_BEAT));
        else if (xfer)    hw_left <= hw_left - LEFT_W'(1);
    end

    // 64->16 unpacker: holds one word, steps through halfwords, drops the tail after the last one
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            word_q <= '0;
            sel_q  <= '0;
            have_q <= 1'b0;
        end else begin
            if (xfer) begin
                if (word_end) have_q <= 1'b0;
                else          sel_q  <= sel_q + 2'd1;
            end
            if (fifo_pop) begin
                word_q <= fifo_dout;
                sel_q  <= '0;
                have_q <= 1'b1;
            end
        end
    end

    // Output halfword select, odd-length masking and optional byte swap
    always_comb begin
        hw = word_q[{sel_q, 4'b0000} +: 16];
        if (last_hw && odd_q) hw[15:8] = '0;
`ifdef H264_RD_BYTE_SWAP_EN
        hw = {hw[7:0], hw[15:8]};
`else
        hw = hw;
`endif
        data_o = have_q ? hw : '0;
    end

    assign data_valid_o = have_q;
    assign last_o       = have_q && last_hw;

endmodule

// File: tb/tb_h264_ddr_read.sv
`timescale 1ns/1ps
module tb_h264_ddr_read;

    logic        sys_clk_i;
    logic        reset_i;
    logic        start_i;
    logic [9:0]  frame_ddr_addr_i;
    logic [1:0]  frame_index_i;
    logic [31:0] frame_bytes_i;
    logic        busy_o;
    logic        done_o;
    logic        read_req_o;
    logic [31:0] read_start_addr_o;
    logic [7:0]  read_length_o;
    logic        read_ackn_i;
    logic        rdata_valid_i;
    logic [63:0] rdata_i;
    logic        read_done_i;
    logic [15:0] data_o;
    logic        data_valid_o;
    logic        data_ready_i;
    logic        last_o;

    h264_ddr_read #(
        .BURST_BEATS     (16),
        .FIFO_DEPTH      (64),
        .SLOT_BYTES_LOG2 (20)
    ) dut (
        .sys_clk_i         (sys_clk_i),
        .reset_i           (reset_i),
        .start_i           (start_i),
        .frame_ddr_addr_i  (frame_ddr_addr_i),
        .frame_index_i     (frame_index_i),
        .frame_bytes_i     (frame_bytes_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .read_req_o        (read_req_o),
        .read_start_addr_o (read_start_addr_o),
        .read_length_o     (read_length_o),
        .read_ackn_i       (read_ackn_i),
        .rdata_valid_i     (rdata_valid_i),
        .rdata_i           (rdata_i),
        .read_done_i       (read_done_i),
        .data_o            (data_o),
        .data_valid_o      (data_valid_o),
        .data_ready_i      (data_ready_i),
        .last_o            (last_o)
    );

    initial sys_clk_i = 1'b0;
    always #5 sys_clk_i = ~sys_clk_i;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [16:0] exp_q[$];     // {last, halfword}
    logic [39:0] burst_q[$];   // {byte address, beats-1}
    int          ready_mode;   // 0 always ready, 1 random, 2 held low
    int          ack_fixed;    // <0 random ack delay, else fixed
    int unsigned beats_delivered;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic report_fail(input string name, input string what);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    // DDR content model: each byte is a fixed function of its address
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] t;
        t = a ^ (a >> 8) ^ (a >> 17) ^ 32'h5a;
        return t[7:0];
    endfunction

    function automatic logic [63:0] beat_data(input logic [31:0] a);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[8*i +: 8] = mem_byte(a + 32'(i));
        return d;
    endfunction

    // Arbiter/DDR model for the r0 port
    initial begin : arbiter
        int st, cnt, bidx;
        logic [31:0] a;
        logic [7:0]  l;
        logic [39:0] e;
        bit          dropchk;
        st = 0; cnt = 0; bidx = 0; dropchk = 0; a = '0; l = '0;
        forever begin
            @(negedge sys_clk_i);
            if (reset_i) begin
                st = 0; read_ackn_i = 0; rdata_valid_i = 0; read_done_i = 0;
                continue;
            end
            case (st)
                0: begin
                    read_ackn_i = 0; rdata_valid_i = 0; read_done_i = 0;
                    if (read_req_o) begin
                        a = read_start_addr_o;
                        l = read_length_o;
                        if (burst_q.size() == 0) begin
                            report_fail("unexpected_req", $sformatf("addr %0h len %0d", a, l));
                        end else begin
                            e = burst_q.pop_front();
                            check("burst_addr", a, e[39:8]);
                            check("burst_len", l, e[7:0]);
                        end
                        cnt = (ack_fixed >= 0) ? ack_fixed : int'($urandom_range(0, 3));
                        bidx = 0; dropchk = 1;
                        if (cnt == 0) begin read_ackn_i = 1; st = 2; end
                        else st = 1;
                    end
                end
                1: begin
                    check("req_hold", read_req_o, 1);
                    check("addr_hold", read_start_addr_o, a);
                    check("len_hold", read_length_o, l);
                    cnt--;
                    if (cnt == 0) begin read_ackn_i = 1; st = 2; end
                end
                2: begin
                    read_ackn_i = 0; rdata_valid_i = 0; read_done_i = 0;
                    if (dropchk) begin check("req_drop", read_req_o, 0); dropchk = 0; end
                    if ($urandom_range(0, 3) != 0) begin
                        rdata_i = beat_data(a + 32'(8 * bidx));
                        rdata_valid_i = 1;
                        bidx++;
                        beats_delivered++;
                        if (bidx == int'(l) + 1) begin
                            if ($urandom_range(0, 1) == 1) begin read_done_i = 1; st = 0; end
                            else st = 3;
                        end
                    end
                end
                default: begin
                    rdata_valid_i = 0; read_done_i = 1; st = 0;
                end
            endcase
        end
    end

    // Output monitor: drives ready, pops the scoreboard on every transfer, checks hold while stalled
    initial begin : monitor
        bit          prev_hold;
        logic [15:0] prev_data;
        logic        prev_last;
        logic        r;
        logic [16:0] e;
        prev_hold = 0; prev_data = '0; prev_last = 0;
        forever begin
            @(negedge sys_clk_i);
            if (reset_i) begin prev_hold = 0; data_ready_i = 0; continue; end
            if (prev_hold) begin
                check("hold_valid", data_valid_o, 1);
                check("hold_data", data_o, prev_data);
                check("hold_last", last_o, prev_last);
            end
            case (ready_mode)
                0:       r = 1'b1;
                1:       r = ($urandom_range(0, 2) != 0);
                default: r = 1'b0;
            endcase
            data_ready_i = r;
            if (data_valid_o && r) begin
                if (exp_q.size() == 0) begin
                    report_fail("extra_output", $sformatf("data %0h last %0b", data_o, last_o));
                end else begin
                    e = exp_q.pop_front();
                    check("halfword", {last_o, data_o}, e);
                end
            end
            prev_hold = data_valid_o && !r;
            prev_data = data_o;
            prev_last = last_o;
        end
    end

    // Reference: frame as a byte string, halfwords little-endian, bursts of up to 16 beats
    task automatic start_frame(input logic [9:0] fa, input logic [1:0] fi, input logic [31:0] fb);
        logic [31:0] base, bytes, off;
        int unsigned nhw, rem, n;
        base  = {fa, fi, 20'h0};
        bytes = (fb > 32'h0010_0000) ? 32'h0010_0000 : fb;
        nhw   = (bytes + 1) / 2;
        for (int unsigned k = 0; k < nhw; k++) begin
            logic [7:0]  lo, hi;
            logic [15:0] h;
            lo = mem_byte(base + 32'(2 * k));
            hi = (2 * k + 1 < bytes) ? mem_byte(base + 32'(2 * k + 1)) : 8'h00;
            h  = {hi, lo};
`ifdef H264_RD_BYTE_SWAP_EN
            h = {h[7:0], h[15:8]};
`endif
            exp_q.push_back({(k == nhw - 1), h});
        end
        off = 0;
        while (off < bytes) begin
            rem = (bytes - off + 7) / 8;
            n   = (rem > 16) ? 16 : rem;
            burst_q.push_back({base + off, 8'(n - 1)});
            off += 32'(n * 8);
        end
        @(negedge sys_clk_i);
        frame_ddr_addr_i = fa; frame_index_i = fi; frame_bytes_i = fb; start_i = 1;
        @(negedge sys_clk_i);
        start_i = 0;
    endtask

    task automatic wait_done(input string name);
        int unsigned t;
        t = 0;
        do begin
            @(negedge sys_clk_i);
            t++;
        end while (!done_o && t < 20000);
        if (!done_o) begin
            report_fail({name, "_timeout"}, "no done_o within 20000 cycles");
            $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
            $fatal(1, "timeout");
        end
        check({name, "_halfwords_left"}, exp_q.size(), 0);
        check({name, "_bursts_left"}, burst_q.size(), 0);
        @(negedge sys_clk_i);
        check({name, "_done_once"}, done_o, 0);
        check({name, "_idle"}, busy_o, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        report_fail("watchdog", "simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int unsigned t;
        n_checks = 0; n_errors = 0;
        ready_mode = 0; ack_fixed = -1; beats_delivered = 0;
        reset_i = 1; start_i = 0; frame_ddr_addr_i = '0; frame_index_i = '0; frame_bytes_i = '0;
        read_ackn_i = 0; rdata_valid_i = 0; rdata_i = '0; read_done_i = 0; data_ready_i = 0;
        repeat (3) @(negedge sys_clk_i);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_req", read_req_o, 0);
        check("rst_addr", read_start_addr_o, 0);
        check("rst_len", read_length_o, 0);
        check("rst_valid", data_valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_last", last_o, 0);
        reset_i = 0;

        // 256 bytes: two full bursts, 128 halfwords
        start_frame(10'h12A, 2'd1, 32'd256);
        check("t1_busy", busy_o, 1);
        wait_done("t1");

        // 8 bytes at the top region/slot
        start_frame(10'h3FF, 2'd2, 32'd8);
        wait_done("t2");

        // 13 bytes: odd tail, last word partly discarded
        ready_mode = 1;
        start_frame(10'h001, 2'd3, 32'd13);
        wait_done("t3");

        // zero-length frame
        beats_delivered = 0;
        start_frame(10'h0AA, 2'd3, 32'd0);
        check("t4_done", done_o, 1);
        check("t4_busy", busy_o, 1);
        @(negedge sys_clk_i);
        check("t4_done_once", done_o, 0);
        check("t4_no_traffic", beats_delivered, 0);

        // backpressure: FIFO fills, further bursts withheld
        ready_mode = 2; beats_delivered = 0;
        start_frame(10'h155, 2'd1, 32'd1024);
        repeat (400) @(negedge sys_clk_i);
        check("t5_fill_beats", beats_delivered, 64);
        check("t5_req_withheld", read_req_o, 0);
        check("t5_valid_held", data_valid_o, 1);
        ready_mode = 1;
        wait_done("t5");

        // reset in the middle of a burst, then a clean fetch with slow acks
        beats_delivered = 0;
        start_frame(10'h2C3, 2'd0, 32'd256);
        t = 0;
        while (beats_delivered < 5 && t < 500) begin @(negedge sys_clk_i); t++; end
        check("t6_reached_wait", (beats_delivered >= 5), 1);
        ready_mode = 2;
        repeat (2) @(negedge sys_clk_i);
        reset_i = 1;
        @(negedge sys_clk_i);
        check("t6_busy", busy_o, 0);
        check("t6_done", done_o, 0);
        check("t6_req", read_req_o, 0);
        check("t6_addr", read_start_addr_o, 0);
        check("t6_len", read_length_o, 0);
        check("t6_valid", data_valid_o, 0);
        check("t6_data", data_o, 0);
        check("t6_last", last_o, 0);
        repeat (2) @(negedge sys_clk_i);
        exp_q.delete();
        burst_q.delete();
        reset_i = 0;
        ready_mode = 1;
        ack_fixed = 5;
        start_frame(10'h2C3, 2'd0, 32'd256);
        wait_done("t6_refetch");
        ack_fixed = -1;

        // random frames; a start pulse mid-frame must be ignored
        for (int i = 0; i < 6; i++) begin
            logic [31:0] nb;
            nb = $urandom_range(1, 700);
            ready_mode = (i % 3 == 0) ? 0 : 1;
            start_frame(10'($urandom), 2'($urandom), nb);
            if (nb >= 200) begin
                repeat (5) @(negedge sys_clk_i);
                if (busy_o) begin
                    frame_ddr_addr_i = 10'h0F0; frame_index_i = 2'd0; frame_bytes_i = 32'd8;
                    start_i = 1;
                    @(negedge sys_clk_i);
                    start_i = 0;
                end
            end
            wait_done("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
